// File: rtl/mul_div_unit_if.sv
// Handshake/bus bundle between the EX stage (master) and the iterative M-extension unit (slave).
interface mul_div_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) ();
  logic             start;
  logic [2:0]       op;
  logic [XLEN-1:0]  src1;
  logic [XLEN-1:0]  src2;
  logic [TAG_W-1:0] tag_i;
  logic             flush;
  logic             busy;
  logic             done;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output start, op, src1, src2, tag_i, flush,
    input  busy, done, result, tag_o
  );

  modport slave (
    input  start, op, src1, src2, tag_i, flush,
    output busy, done, result, tag_o
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32/64 M-extension unit: shift-add multiplier and restoring divider, one bit per cycle.
// Optional feature macro: MDU_FAST_MUL_EN (single-cycle combinational multiply; divides stay iterative).
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  ZERO_X   = {XLEN{1'b0}};

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [XLEN-1:0]  r_result;
  logic [TAG_W-1:0] r_tag_o;
  logic [TAG_W-1:0] r_pend_tag;
  logic [2:0]       r_op;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic             r_neg_a;
  logic             r_neg_b;

  logic             w_accept;
  logic             w_s1_signed;
  logic             w_s2_signed;
  logic             w_s1_neg;
  logic             w_s2_neg;
  logic [XLEN-1:0]  w_abs1;
  logic [XLEN-1:0]  w_abs2;
  logic             w_special;
  logic [XLEN-1:0]  w_special_res;
  logic [XLEN:0]    w_mul_sum;
  logic [XLEN:0]    w_div_trial;
  logic [XLEN-1:0]  w_hi_nxt;
  logic [XLEN-1:0]  w_lo_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]  w_quo_fix;
  logic [XLEN-1:0]  w_rem_fix;
  logic [XLEN-1:0]  w_final;

  assign w_accept = bus.start && !r_busy && !bus.flush;

  // Operand sign handling and magnitudes taken at launch.
  always_comb begin
    w_s1_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                  (bus.op == OP_DIV)  || (bus.op == OP_REM);
    w_s2_signed = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    w_s1_neg    = w_s1_signed && bus.src1[XLEN-1];
    w_s2_neg    = w_s2_signed && bus.src2[XLEN-1];
    if (w_s1_neg) begin
      w_abs1 = -bus.src1;
    end else begin
      w_abs1 = bus.src1;
    end
    if (w_s2_neg) begin
      w_abs2 = -bus.src2;
    end else begin
      w_abs2 = bus.src2;
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [XLEN:0]     w_fast_a;
  logic signed [XLEN:0]     w_fast_b;
  logic signed [2*XLEN+1:0] w_fast_prod;

  // Full-width signed product of sign/zero-extended operands covers all four multiply flavours.
  always_comb begin
    w_fast_a    = $signed({w_s1_signed & bus.src1[XLEN-1], bus.src1});
    w_fast_b    = $signed({w_s2_signed & bus.src2[XLEN-1], bus.src2});
    w_fast_prod = w_fast_a * w_fast_b;
  end
`endif

  // Results that complete without iterating: divide-by-zero, signed overflow, optional fast multiply.
  always_comb begin
    w_special     = 1'b0;
    w_special_res = ZERO_X;
    if (bus.op[2] && (bus.src2 == ZERO_X)) begin
      w_special = 1'b1;
      if (bus.op[1]) begin
        w_special_res = bus.src1;
      end else begin
        w_special_res = ALL_ONES;
      end
    end else if (((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                 (bus.src1 == MIN_INT) && (bus.src2 == ALL_ONES)) begin
      w_special = 1'b1;
      if (bus.op[1]) begin
        w_special_res = ZERO_X;
      end else begin
        w_special_res = bus.src1;
      end
    end else begin
`ifdef MDU_FAST_MUL_EN
      if (!bus.op[2]) begin
        w_special = 1'b1;
        if (bus.op == OP_MUL) begin
          w_special_res = w_fast_prod[XLEN-1:0];
        end else begin
          w_special_res = w_fast_prod[2*XLEN-1:XLEN];
        end
      end else begin
        w_special     = 1'b0;
        w_special_res = ZERO_X;
      end
`else
      w_special     = 1'b0;
      w_special_res = ZERO_X;
`endif
    end
  end

  // One iteration step: {hi,lo} is the product shifter or the remainder/quotient pair.
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
    w_div_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_a};
    if (r_op[2]) begin
      if (!w_div_trial[XLEN]) begin
        w_hi_nxt = w_div_trial[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nxt = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_mul_sum[XLEN:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // Sign fixup and result select applied to the final iteration's output.
  always_comb begin
    w_prod = {w_hi_nxt, w_lo_nxt};
    if (r_neg_a) begin
      w_prod_fix = -w_prod;
      w_quo_fix  = -w_lo_nxt;
    end else begin
      w_prod_fix = w_prod;
      w_quo_fix  = w_lo_nxt;
    end
    if (r_neg_b) begin
      w_rem_fix = -w_hi_nxt;
    end else begin
      w_rem_fix = w_hi_nxt;
    end
    case (r_op)
      OP_MUL:                       w_final = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_final = w_quo_fix;
      OP_REM, OP_REMU:              w_final = w_rem_fix;
      default:                      w_final = ZERO_X;
    endcase
  end

  // Control FSM with registered outputs; flush overrides everything except reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= ZERO_X;
      r_tag_o    <= {TAG_W{1'b0}};
      r_pend_tag <= {TAG_W{1'b0}};
      r_op       <= 3'd0;
      r_a        <= ZERO_X;
      r_hi       <= ZERO_X;
      r_lo       <= ZERO_X;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_op       <= bus.op;
            r_pend_tag <= bus.tag_i;
            r_cnt      <= {CNT_W{1'b0}};
            r_neg_a    <= w_s1_neg ^ w_s2_neg;
            r_neg_b    <= w_s1_neg;
            r_hi       <= ZERO_X;
            if (bus.op[2]) begin
              r_a  <= w_abs2;
              r_lo <= w_abs1;
            end else begin
              r_a  <= w_abs1;
              r_lo <= w_abs2;
            end
            if (w_special) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= w_special_res;
              r_tag_o  <= bus.tag_i;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_CALC: begin
          r_hi <= w_hi_nxt;
          r_lo <= w_lo_nxt;
          if (r_cnt == LAST_CNT) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_final;
            r_tag_o  <= r_pend_tag;
          end else begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.tag_o  = r_tag_o;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit (XLEN=32): expectations queued at launch, compared at done.
module tb_mul_div_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
    logic [7:0]  lat;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   checks;
  int   failures;
  logic [31:0] last_res;
  logic [4:0]  last_tag;

  mul_div_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  mul_div_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    p = 64'd0;
    r = 32'd0;
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); r = p[63:32]; end
      3'd2: begin p = longint'($signed(a)) * longint'({32'd0, b}); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = $signed(a) / $signed(b);
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 32'd0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    bus.start = st;
    bus.op    = op;
    bus.src1  = a;
    bus.src2  = b;
    bus.tag_i = tag;
  endtask

  // Launch one op, wait (bounded) for done, then pop the scoreboard and compare.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp_res, input string name);
    exp_t e;
    exp_t got;
    int   lat;
    bit   seen;
    e.res = exp_res;
    e.tag = tag;
    e.lat = 8'(exp_lat(op, a, b));
    sb.push_back(e);
    drive(1'b1, op, a, b, tag);
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 60 && !seen; n++) begin
      if (n == 1 && e.lat > 8'd1) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy_after_start got=%b exp=1", name, bus.busy);
        end
      end
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        lat  = n;
      end else begin
        @(negedge clk);
      end
    end
    got = sb.pop_front();
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s done_timeout waited=60 exp_lat=%0d", name, got.lat);
    end else begin
      if (bus.result !== got.res) begin
        failures++;
        $display("FAIL %s result got=%h exp=%h", name, bus.result, got.res);
      end
      checks++;
      if (bus.tag_o !== got.tag) begin
        failures++;
        $display("FAIL %s tag got=%0d exp=%0d", name, bus.tag_o, got.tag);
      end
      checks++;
      if (lat != int'(got.lat)) begin
        failures++;
        $display("FAIL %s latency got=%0d exp=%0d", name, lat, got.lat);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.result !== got.res) begin
        failures++;
        $display("FAIL %s done_pulse_hold done=%b result=%h exp_done=0 exp_result=%h",
                 name, bus.done, bus.result, got.res);
      end
      last_res = got.res;
      last_tag = got.tag;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0 || bus.tag_o !== 5'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b result=%h tag=%0d exp=0/0/0/0",
               bus.busy, bus.done, bus.result, bus.tag_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, "mul_7");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, "mulh_min");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, "mulhu_max");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, "mulhsu_m1");
  endtask

  task automatic test_div;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, "rem_m7_2");
    run_op(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, "remu_100_7");
  endtask

  task automatic test_special;
    run_op(3'd4, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, "div_by_zero");
    run_op(3'd7, 32'd5, 32'd0, 5'd11, 32'd5, "remu_by_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, "div_overflow");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, "rem_overflow");
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 4 == 3) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op(op, a, b, 5'(i + 14), model(op, a, b), "random");
    end
  endtask

  task automatic test_flush;
    bit saw_done;
    drive(1'b1, 3'd5, 32'd1000, 32'd3, 5'd20);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_pre_busy got=%b exp=1", bus.busy);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy got=%b exp=0", bus.busy);
    end
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_done || bus.result !== last_res || bus.tag_o !== last_tag) begin
      failures++;
      $display("FAIL flush_no_done saw_done=%b result=%h tag=%0d exp_done=0 exp_result=%h exp_tag=%0d",
               saw_done, bus.result, bus.tag_o, last_res, last_tag);
    end
    drive(1'b1, 3'd5, 32'd77, 32'd7, 5'd21);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    saw_done  = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_start_busy got=%b exp=0", bus.busy);
    end
    for (int n = 0; n < 40; n++) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_done || bus.result !== last_res) begin
      failures++;
      $display("FAIL flush_start_dropped saw_done=%b result=%h exp_done=0 exp_result=%h",
               saw_done, bus.result, last_res);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    exp_t got;
    int   lat;
    bit   seen;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        e.res = 32'd14; e.tag = 5'd4; e.lat = 8'd33;
        sb.push_back(e);
        drive(1'b1, 3'd5, 32'd100, 32'd7, 5'd4);
        @(negedge clk);
        drive(1'b1, 3'd5, 32'd50, 32'd5, 5'd6);
      end else begin
        e.res = 32'd100; e.tag = 5'd9; e.lat = 8'd33;
        sb.push_back(e);
        drive(1'b1, 3'd5, 32'd1000, 32'd10, 5'd9);
        @(negedge clk);
        bus.start = 1'b0;
      end
      seen = 1'b0;
      lat  = 0;
      for (int n = 1; n <= 60 && !seen; n++) begin
        if (bus.done === 1'b1) begin
          seen = 1'b1;
          lat  = n;
        end else begin
          @(negedge clk);
        end
      end
      got = sb.pop_front();
      checks++;
      if (!seen || bus.result !== got.res || bus.tag_o !== got.tag || lat != int'(got.lat)) begin
        failures++;
        $display("FAIL back_to_back_%0d seen=%b result=%h tag=%0d lat=%0d exp_result=%h exp_tag=%0d exp_lat=%0d",
                 k, seen, bus.result, bus.tag_o, lat, got.res, got.tag, got.lat);
      end
      last_res = got.res;
      last_tag = got.tag;
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 3'd4, 32'd12345, 32'd17, 5'd25);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0 || bus.tag_o !== 5'd0) begin
      failures++;
      $display("FAIL reset_mid busy=%b done=%b result=%h tag=%0d exp=0/0/0/0",
               bus.busy, bus.done, bus.result, bus.tag_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'd5, 32'd12345, 32'd17, 5'd26, 32'd726, "after_reset");
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    checks   = 0;
    failures = 0;
    last_res = 32'd0;
    last_tag = 5'd0;
    bus.flush = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
